// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: state encoding,
// MDU latency defaults and the hard-wired zero register index.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      LU_STALL  = 2'd1,
      MDU_STALL = 2'd2,
      FLUSH     = 2'd3
   } ctrl_state_t;

   localparam int unsigned MUL_LATENCY_DEF = 4;
   localparam int unsigned DIV_LATENCY_DEF = 32;

   localparam logic [4:0] REG_ZERO = '0;

endpackage

// File: rtl/pipeline_stall_ctrl_mdu_busy_counter.sv
// Multiply/divide occupancy counter: loads latency-1 on a start, counts down to
// zero and flags the unit busy while non-zero.
module mdu_busy_counter
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF,
   parameter int unsigned DIV_LATENCY = DIV_LATENCY_DEF,
   parameter int unsigned CNT_W       = 6
) (
   input  logic clk,
   input  logic rst,
   input  logic start_mul,
   input  logic start_div,
   output logic busy
);

   logic [CNT_W-1:0] count;

   // Divide wins a simultaneous start; a start while busy simply reloads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (start_div) begin
         count <= CNT_W'(DIV_LATENCY - 1);
      end else if (start_mul) begin
         count <= CNT_W'(MUL_LATENCY - 1);
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign busy = (count != '0);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer beside the ID/EX forwarding unit: Mealy hazard decode,
// registered sequencing state, MDU occupancy tracking and a stall perf counter.
module pipeline_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF,
   parameter int unsigned DIV_LATENCY = DIV_LATENCY_DEF,
   parameter int unsigned CNT_W       = 6,
   parameter int unsigned PERF_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              IDEXMemRead,
   input  logic [4:0]        IDEXRegisterRt,
   input  logic [4:0]        IFIDRegisterRs,
   input  logic [4:0]        IFIDRegisterRt,
   input  logic              IFIDUsesRt,
   input  logic              IFIDReadsHiLo,
   input  logic              IFIDIsMdu,
   input  logic              BranchTaken,
   input  logic              MduStartMul,
   input  logic              MduStartDiv,
   output logic              PCWrite,
   output logic              IFIDWrite,
   output logic              stall,
   output logic              IFIDFlush,
   output logic              IDEXFlush,
   output logic              MduBusy,
   output logic [PERF_W-1:0] StallCycles
);

   ctrl_state_t       state;
   ctrl_state_t       state_next;
   logic              lu_raw;
   logic              lu;
   logic              md;
   logic [PERF_W-1:0] perf;

   mdu_busy_counter #(
      .MUL_LATENCY (MUL_LATENCY),
      .DIV_LATENCY (DIV_LATENCY),
      .CNT_W       (CNT_W)
   ) u_mdu (
      .clk       (clk),
      .rst       (rst),
      .start_mul (MduStartMul),
      .start_div (MduStartDiv),
      .busy      (MduBusy)
   );

   assign lu_raw = IDEXMemRead && (IDEXRegisterRt != REG_ZERO) &&
                   ((IDEXRegisterRt == IFIDRegisterRs) ||
                    (IFIDUsesRt && (IDEXRegisterRt == IFIDRegisterRt)));
   // A repeated load-use seen during LU_STALL is a protocol error and is masked,
   // capping back-to-back load-use stalls at one cycle.
   assign lu = lu_raw && (state != LU_STALL);
   assign md = MduBusy && (IFIDReadsHiLo || IFIDIsMdu);

   always_comb begin
      PCWrite   = 1'b1;
      IFIDWrite = 1'b1;
      stall     = 1'b0;
      IFIDFlush = 1'b0;
      IDEXFlush = 1'b0;
      if (BranchTaken) begin
         IFIDFlush = 1'b1;
         IDEXFlush = 1'b1;
      end else if (lu || md) begin
         PCWrite   = 1'b0;
         IFIDWrite = 1'b0;
         stall     = 1'b1;
      end
   end

   always_comb begin
      state_next = RUN;
      if (state == LU_STALL) begin
         state_next = RUN;
      end else if (BranchTaken) begin
         state_next = FLUSH;
      end else if (lu) begin
         state_next = LU_STALL;
      end else if (md) begin
         state_next = MDU_STALL;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         perf  <= '0;
      end else begin
         state <= state_next;
         if (stall && (perf != '1)) begin
            perf <= perf + 1'b1;
         end
      end
   end

   assign StallCycles = perf;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: load-use, register-zero, MDU divide
// stall, simultaneous starts, branch priority and asynchronous reset mid-divide.
module tb_pipeline_stall_ctrl;
   import pipe_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        IDEXMemRead;
   logic [4:0]  IDEXRegisterRt;
   logic [4:0]  IFIDRegisterRs;
   logic [4:0]  IFIDRegisterRt;
   logic        IFIDUsesRt;
   logic        IFIDReadsHiLo;
   logic        IFIDIsMdu;
   logic        BranchTaken;
   logic        MduStartMul;
   logic        MduStartDiv;
   logic        PCWrite;
   logic        IFIDWrite;
   logic        stall;
   logic        IFIDFlush;
   logic        IDEXFlush;
   logic        MduBusy;
   logic [15:0] StallCycles;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   always #5 clk = ~clk;

   pipeline_stall_ctrl #(
      .MUL_LATENCY (4),
      .DIV_LATENCY (32),
      .CNT_W       (6),
      .PERF_W      (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .IDEXMemRead    (IDEXMemRead),
      .IDEXRegisterRt (IDEXRegisterRt),
      .IFIDRegisterRs (IFIDRegisterRs),
      .IFIDRegisterRt (IFIDRegisterRt),
      .IFIDUsesRt     (IFIDUsesRt),
      .IFIDReadsHiLo  (IFIDReadsHiLo),
      .IFIDIsMdu      (IFIDIsMdu),
      .BranchTaken    (BranchTaken),
      .MduStartMul    (MduStartMul),
      .MduStartDiv    (MduStartDiv),
      .PCWrite        (PCWrite),
      .IFIDWrite      (IFIDWrite),
      .stall          (stall),
      .IFIDFlush      (IFIDFlush),
      .IDEXFlush      (IDEXFlush),
      .MduBusy        (MduBusy),
      .StallCycles    (StallCycles)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Packs {PCWrite, IFIDWrite, stall, IFIDFlush, IDEXFlush}.
   function automatic logic [31:0] ctl();
      return {27'd0, PCWrite, IFIDWrite, stall, IFIDFlush, IDEXFlush};
   endfunction

   task automatic clear_inputs();
      IDEXMemRead    = 1'b0;
      IDEXRegisterRt = 5'd0;
      IFIDRegisterRs = 5'd0;
      IFIDRegisterRt = 5'd0;
      IFIDUsesRt     = 1'b0;
      IFIDReadsHiLo  = 1'b0;
      IFIDIsMdu      = 1'b0;
      BranchTaken    = 1'b0;
      MduStartMul    = 1'b0;
      MduStartDiv    = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] CTL_RUN   = 32'b11000;
   localparam logic [31:0] CTL_STALL = 32'b00100;
   localparam logic [31:0] CTL_FLUSH = 32'b11011;

   initial begin
      clear_inputs();
      rst = 1'b1;
      #2;
      check("reset_ctl", ctl(), CTL_RUN);
      check("reset_busy", 32'(MduBusy), 32'd0);
      check("reset_perf", 32'(StallCycles), 32'd0);
      check("reset_state", 32'(dut.state), 32'(RUN));
      @(negedge clk);
      rst = 1'b0;
      tick();

      // lw $5 in EX, add using $5 in ID
      IDEXMemRead = 1'b1; IDEXRegisterRt = 5'd5; IFIDRegisterRs = 5'd5;
      #1 check("lu_ctl", ctl(), CTL_STALL);
      tick();
      check("lu_state", 32'(dut.state), 32'(LU_STALL));
      check("lu_perf", 32'(StallCycles), 32'd1);
      check("lu_repeat_masked", ctl(), CTL_RUN);
      clear_inputs();
      tick();
      check("lu_back_to_run", 32'(dut.state), 32'(RUN));
      check("lu_perf_hold", 32'(StallCycles), 32'd1);

      // register zero and unused Rt never stall
      IDEXMemRead = 1'b1; IDEXRegisterRt = 5'd0; IFIDRegisterRs = 5'd0;
      #1 check("reg0_no_stall", ctl(), CTL_RUN);
      IDEXRegisterRt = 5'd7; IFIDRegisterRs = 5'd3; IFIDRegisterRt = 5'd7; IFIDUsesRt = 1'b0;
      #1 check("rt_unused_no_stall", ctl(), CTL_RUN);
      IFIDUsesRt = 1'b1;
      #1 check("rt_used_stall", ctl(), CTL_STALL);
      clear_inputs();
      #1 check("idle_run", ctl(), CTL_RUN);
      tick();

      // divide then mfhi held in ID: 31 stalled cycles
      MduStartDiv = 1'b1;
      #1 check("div_start_not_busy", 32'(MduBusy), 32'd0);
      tick();
      MduStartDiv = 1'b0; IFIDReadsHiLo = 1'b1;
      check("div_count_load", 32'(dut.u_mdu.count), 32'd31);
      for (int i = 0; i < 31; i++) begin
         #1;
         check($sformatf("div_busy_%0d", i), 32'(MduBusy), 32'd1);
         check($sformatf("div_stall_%0d", i), ctl(), CTL_STALL);
         tick();
      end
      check("div_done_busy", 32'(MduBusy), 32'd0);
      check("div_done_ctl", ctl(), CTL_RUN);
      check("div_perf", 32'(StallCycles), 32'd32);
      check("div_state", 32'(dut.state), 32'(MDU_STALL));
      clear_inputs();
      tick();
      check("div_state_run", 32'(dut.state), 32'(RUN));

      // branch beats a coincident load-use
      BranchTaken = 1'b1; IDEXMemRead = 1'b1; IDEXRegisterRt = 5'd9; IFIDRegisterRs = 5'd9;
      #1 check("br_ctl", ctl(), CTL_FLUSH);
      tick();
      clear_inputs();
      check("br_state", 32'(dut.state), 32'(FLUSH));
      check("br_perf_unchanged", 32'(StallCycles), 32'd32);
      tick();
      check("br_back_to_run", 32'(dut.state), 32'(RUN));

      // simultaneous starts: divide latency wins
      MduStartMul = 1'b1; MduStartDiv = 1'b1;
      tick();
      clear_inputs();
      check("both_start_count", 32'(dut.u_mdu.count), 32'd31);
      IFIDReadsHiLo = 1'b1;
      for (int i = 0; i < 19; i++) tick();
      check("mid_div_count", 32'(dut.u_mdu.count), 32'd12);
      check("mid_div_stall", ctl(), CTL_STALL);
      check("mid_div_perf", 32'(StallCycles), 32'd51);

      // asynchronous reset mid-divide, well before the next edge
      #1 rst = 1'b1;
      #1;
      check("arst_busy", 32'(MduBusy), 32'd0);
      check("arst_ctl", ctl(), CTL_RUN);
      check("arst_perf", 32'(StallCycles), 32'd0);
      check("arst_count", 32'(dut.u_mdu.count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("arst_state_run", 32'(dut.state), 32'(RUN));
      check("arst_no_stall", ctl(), CTL_RUN);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline. It sits beside the forwarding unit in ID/EX.
- Detects load-use hazards and taken-branch flushes, and tracks a multi-cycle multiply/divide unit (MDU).
- Drives PC, IF/ID and ID/EX control from a small state machine and a busy counter.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MUL_LATENCY, 4, cycles an MDU multiply occupies the unit (must be at least 2).
- DIV_LATENCY, 32, cycles an MDU divide occupies the unit (must be at least 2).
- CNT_W, 6, width of the MDU busy counter (must be at least clog2(max latency)+1).
- PERF_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- IDEXMemRead  in  1  instruction in EX is a load.
- IDEXRegisterRt  in  5  load destination register.
- IFIDRegisterRs  in  5  Rs of the instruction in ID.
- IFIDRegisterRt  in  5  Rt of the instruction in ID.
- IFIDUsesRt  in  1  ID instruction reads Rt as a source (R-type, store, beq).
- IFIDReadsHiLo  in  1  ID instruction is mfhi or mflo.
- IFIDIsMdu  in  1  ID instruction is mult or div.
- BranchTaken  in  1  branch or jump resolved taken in EX.
- MduStartMul  in  1  multiply enters EX this cycle.
- MduStartDiv  in  1  divide enters EX this cycle.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register update enable.
- stall  out  1  zero ID/EX control signals, i.e. insert a bubble.
- IFIDFlush  out  1  clear IF/ID to nop.
- IDEXFlush  out  1  clear ID/EX to nop.
- MduBusy  out  1  MDU busy counter is non-zero.
- StallCycles  out  PERF_W  saturating count of stalled cycles.

Behaviour:
- Hazard conditions, all combinational on current inputs and registered state:
  - LU = IDEXMemRead AND IDEXRegisterRt != 0 AND (IDEXRegisterRt == IFIDRegisterRs OR (IFIDUsesRt AND IDEXRegisterRt == IFIDRegisterRt)).
  - MD = MduBusy AND (IFIDReadsHiLo OR IFIDIsMdu).
- Priority is BranchTaken > LU > MD > none.
- BranchTaken: IFIDFlush=1, IDEXFlush=1, PCWrite=1, IFIDWrite=1, stall=0.
- LU or MD: PCWrite=0, IFIDWrite=0, stall=1, both flushes 0.
- No condition: PCWrite=1, IFIDWrite=1, all others 0.
- Outputs react in the same cycle as the condition, with zero latency. This is a Mealy decode.
- FSM, registered, reset state RUN:
  - RUN -> FLUSH on BranchTaken; -> LU_STALL on LU; -> MDU_STALL on MD; else stays in RUN.
  - LU_STALL -> RUN after exactly one cycle. If LU is still true while in LU_STALL (protocol error), it is ignored: outputs force run values for that cycle. This caps consecutive load-use stalls at 1.
  - MDU_STALL stays while MD is true. It goes to FLUSH if BranchTaken, else to RUN.
  - FLUSH -> RUN after one cycle. It re-evaluates the priority decode in its own cycle.
- MDU counter:
  - MduStartDiv loads DIV_LATENCY-1. Else MduStartMul loads MUL_LATENCY-1. Div wins if both starts are asserted.
  - Otherwise it decrements when non-zero and holds at 0.
  - A start while busy reloads the counter. This cannot occur legally because MD stalls a second mult/div.
  - MduBusy = (counter != 0), registered-counter based. The result is readable on the cycle the counter is 0.
- StallCycles increments on every cycle with stall=1 and saturates at all ones. Flush cycles are not counted.
- Reset, asynchronous and immediate, also valid mid-stall:
  - state=RUN, counter=0, StallCycles=0.
  - Outputs go to PCWrite=1, IFIDWrite=1, stall=0, IFIDFlush=0, IDEXFlush=0, MduBusy=0.
- Register 0 never causes a load-use stall.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state encoding (RUN, LU_STALL, MDU_STALL, FLUSH; 2-bit);
  - the MDU latency defaults;
  - the REG_ZERO constant.
- One natural sub-module, mdu_busy_counter: load/decrement counter plus busy flag.
- The FSM, hazard decode and perf counter stay in the top module.

Test Plan:
- lw $5 in EX (IDEXMemRead=1, Rt=5) with add Rs=5 in ID -> one cycle of PCWrite=0, IFIDWrite=0, stall=1; state LU_STALL then RUN; StallCycles=1.
- IDEXMemRead=1, Rt=0, IFIDRegisterRs=0 -> no stall. Rt=7 matches IFIDRegisterRt=7 with IFIDUsesRt=0 -> no stall.
- MduStartDiv pulse, then mfhi held in ID -> MduBusy high for 31 cycles and stall=1 for those 31 cycles; PCWrite=1 on the cycle the counter reaches 0; StallCycles=31.
- MduStartMul with DIV also asserted in the same cycle -> counter loads 31, not 3.
- BranchTaken coincident with load-use -> IFIDFlush=1, IDEXFlush=1, stall=0, PCWrite=1; state FLUSH; StallCycles unchanged.
- rst asserted mid divide (counter=12) -> MduBusy=0 and outputs go to run values asynchronously, before the next edge; state RUN after release.
